// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues tagged commands to a one-cycle ALU, screens
// illegal operations and returns results in order through a response FIFO.
module alu_issue_ctrl #(
    parameter int DATA_W     = 4,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_opcode,
    input  logic                  cmd_signed,
    input  logic [DATA_W-1:0]     cmd_a,
    input  logic [DATA_W-1:0]     cmd_b,
    input  logic [TAG_W-1:0]      cmd_tag,
    output logic [3+2*DATA_W:0]   iw,
    input  logic [DATA_W-1:0]     alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  rsp_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              s1_valid, s2_valid;
    logic              s1_err, s2_err;
    logic [TAG_W-1:0]  s1_tag, s2_tag;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       credit_used;
    logic              accept, cmd_err, push, pop;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [TAG_W-1:0]  fifo_tag  [FIFO_DEPTH];
    logic              fifo_err  [FIFO_DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every in-flight command holds a FIFO slot, so the FIFO cannot overflow.
    assign credit_used = (CW+1)'(count) + (CW+1)'(s1_valid)
                       + (CW+1)'(s2_valid);
    assign cmd_ready   = !rst && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign accept      = cmd_valid && cmd_ready;

    assign cmd_err = cmd_opcode[2]
                   || (cmd_opcode == OP_DIV && cmd_b == '0)
                   || (cmd_opcode == OP_DIV && cmd_signed
                       && cmd_a == MOST_NEG && cmd_b == '1);

    assign push      = s2_valid;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_data = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_tag  = rsp_valid ? fifo_tag[rd_ptr]  : '0;
    assign rsp_err  = rsp_valid ? fifo_err[rd_ptr]  : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            iw       <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_tag   <= '0;
            s1_err   <= 1'b0;
            s2_tag   <= '0;
            s2_err   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                // Illegal ops become a harmless ADD 0+0 but keep their slot.
                iw     <= cmd_err ? '0
                                  : {cmd_opcode, cmd_signed, cmd_a, cmd_b};
                s1_tag <= cmd_tag;
                s1_err <= cmd_err;
            end
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_err   <= s1_err;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_data[wr_ptr] <= s2_err ? '0 : alu_out;
            fifo_tag[wr_ptr]  <= s2_tag;
            fifo_err[wr_ptr]  <= s2_err;
        end
    end

endmodule
